// File: rtl/l2_controller.sv
// rtl/l2_controller.sv - Direct-mapped write-back write-allocate L2 cache controller
module l2_controller #(
  parameter int ADDR_W = 26,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_L1_L2,
  input  logic              write_L1_L2,
  input  logic [19:0]       tag_L1_L2,
  input  logic [19:0]       write_tag_L1_L2,
  input  logic [5:0]        index_L1_L2,
  output logic              ready_L2_L1,
  output logic              read_L2_MEM,
  output logic              write_L2_MEM,
  output logic [ADDR_W-1:0] addr_L2_MEM,
  input  logic              ready_MEM_L2,
  output logic [IDX_W-1:0]  index_L2,
  output logic              refill_L2,
  output logic              update_L2
);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE,
    S_DONE,
    S_GUARD
  } state_t;

  state_t state;
  state_t state_next;

  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;

  logic [LINES-1:0]  valid_arr;
  logic [LINES-1:0]  dirty_arr;
  logic [TAG_W-1:0]  tag_arr [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              victim_dirty;

  logic              accept;
  logic              install;
  logic              clear_dirty;

  // A write request wins over a simultaneous read; the read is picked up on a later acceptance.
  assign req_valid = read_L1_L2 | write_L1_L2;
  assign req_addr  = write_L1_L2 ? {write_tag_L1_L2, index_L1_L2} : {tag_L1_L2, index_L1_L2};

  assign idx          = addr_q[IDX_W-1:0];
  assign tag          = addr_q[ADDR_W-1:IDX_W];
  assign hit          = valid_arr[idx] && (tag_arr[idx] == tag);
  assign victim_dirty = !hit && valid_arr[idx] && dirty_arr[idx];
  assign index_L2     = idx;

  // State register and request latch; the latch is only written on acceptance in S_IDLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      op_write <= 1'b0;
      addr_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_write <= write_L1_L2;
        addr_q   <= req_addr;
      end
    end
  end

  // Line state: install on refill or L1 write, clear dirty once the victim reaches memory.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_arr <= '0;
      dirty_arr <= '0;
      for (int k = 0; k < LINES; k++) begin
        tag_arr[k] <= '0;
      end
    end else begin
      if (install) begin
        valid_arr[idx] <= 1'b1;
        dirty_arr[idx] <= update_L2;
        tag_arr[idx]   <= tag;
      end else if (clear_dirty) begin
        dirty_arr[idx] <= 1'b0;
      end
    end
  end

  // Next-state decode with Moore memory/ready strobes and transition-coupled data strobes.
  always_comb begin
    state_next   = state;
    ready_L2_L1  = 1'b0;
    read_L2_MEM  = 1'b0;
    write_L2_MEM = 1'b0;
    addr_L2_MEM  = '0;
    refill_L2    = 1'b0;
    update_L2    = 1'b0;
    accept       = 1'b0;
    install      = 1'b0;
    clear_dirty  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (victim_dirty) begin
          state_next = S_WRITE_BACK;
        end else if (op_write) begin
          // Full-block write: no fill from memory is needed before installing.
          update_L2  = 1'b1;
          install    = 1'b1;
          state_next = S_DONE;
        end else if (hit) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        write_L2_MEM = 1'b1;
        addr_L2_MEM  = {tag_arr[idx], idx};
        if (ready_MEM_L2) begin
          clear_dirty = 1'b1;
          state_next  = op_write ? S_COMPARE : S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        read_L2_MEM = 1'b1;
        addr_L2_MEM = addr_q;
        if (ready_MEM_L2) begin
          refill_L2  = 1'b1;
          install    = 1'b1;
          state_next = S_COMPARE;
        end
      end
      S_DONE: begin
        ready_L2_L1 = 1'b1;
        state_next  = S_GUARD;
      end
      S_GUARD: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_controller.sv
// tb/tb_l2_controller.sv - Randomized self-checking bench for l2_controller
module tb_l2_controller;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        read_L1_L2 = 1'b0;
  logic        write_L1_L2 = 1'b0;
  logic [19:0] tag_L1_L2 = '0;
  logic [19:0] write_tag_L1_L2 = '0;
  logic [5:0]  index_L1_L2 = '0;
  logic        ready_L2_L1;
  logic        read_L2_MEM;
  logic        write_L2_MEM;
  logic [25:0] addr_L2_MEM;
  logic        ready_MEM_L2 = 1'b0;
  logic [7:0]  index_L2;
  logic        refill_L2;
  logic        update_L2;

  int checks = 0;
  int failures = 0;
  int txn_id = 0;

  bit          m_valid [256];
  bit          m_dirty [256];
  logic [17:0] m_tag   [256];

  l2_controller #(.ADDR_W(26), .IDX_W(8)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .read_L1_L2      (read_L1_L2),
    .write_L1_L2     (write_L1_L2),
    .tag_L1_L2       (tag_L1_L2),
    .write_tag_L1_L2 (write_tag_L1_L2),
    .index_L1_L2     (index_L1_L2),
    .ready_L2_L1     (ready_L2_L1),
    .read_L2_MEM     (read_L2_MEM),
    .write_L2_MEM    (write_L2_MEM),
    .addr_L2_MEM     (addr_L2_MEM),
    .ready_MEM_L2    (ready_MEM_L2),
    .index_L2        (index_L2),
    .refill_L2       (refill_L2),
    .update_L2       (update_L2)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d got=0x%0h exp=0x%0h", name, txn_id, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 256; k++) begin
      m_valid[k] = 1'b0;
      m_dirty[k] = 1'b0;
      m_tag[k]   = '0;
    end
  endtask

  function automatic logic [38:0] all_outputs();
    return {ready_L2_L1, read_L2_MEM, write_L2_MEM, refill_L2, update_L2, addr_L2_MEM, index_L2};
  endfunction

  // One L1 request, served by a memory responder with write/read latencies lw/lr,
  // checked against the cache model for memory traffic, strobes and latency.
  task automatic run_txn(input bit is_wr, input logic [19:0] t, input logic [5:0] i,
                         input int lw, input int lr, input bit with_read,
                         input logic [19:0] rt, input bit hold);
    logic [25:0] a;
    logic [7:0]  li;
    logic [17:0] lt;
    bit          hit, vdirty, rmiss, done;
    int          exp_lat, exp_nops, got_nops;
    logic [26:0] exp_op [2];
    logic [26:0] got_op [4];
    int          cyc, post, done_cyc, refill_n, update_n, ready_n, mutex_n;
    int          prev_kind, cur_kind, wait_n;
    logic [7:0]  idx_at_done;

    txn_id++;
    a  = {t, i};
    li = a[7:0];
    lt = a[25:8];
    hit    = m_valid[li] && (m_tag[li] == lt);
    vdirty = !hit && m_valid[li] && m_dirty[li];
    rmiss  = !is_wr && !hit;
    exp_nops = 0;
    exp_op[0] = '0;
    exp_op[1] = '0;
    if (vdirty) begin
      exp_op[exp_nops] = {1'b1, m_tag[li], li};
      exp_nops++;
    end
    if (rmiss) begin
      exp_op[exp_nops] = {1'b0, a};
      exp_nops++;
    end
    // compare+done = 2; each memory phase costs latency+1; a fill or a post-writeback
    // install each needs one more compare pass.
    exp_lat = 2 + (vdirty ? lw + 1 : 0) + (rmiss ? lr + 2 : 0) + ((is_wr && vdirty) ? 1 : 0);
    m_dirty[li] = is_wr ? 1'b1 : (hit ? m_dirty[li] : 1'b0);
    m_valid[li] = 1'b1;
    m_tag[li]   = lt;

    if (is_wr) begin
      write_L1_L2     = 1'b1;
      write_tag_L1_L2 = t;
    end else begin
      read_L1_L2 = 1'b1;
      tag_L1_L2  = t;
    end
    if (with_read) begin
      read_L1_L2 = 1'b1;
      tag_L1_L2  = rt;
    end
    index_L1_L2 = i;

    cyc = 0; post = 0; done = 0; done_cyc = 0; refill_n = 0; update_n = 0;
    ready_n = 0; mutex_n = 0; prev_kind = 0; wait_n = 0; got_nops = 0;
    idx_at_done = '0;
    for (int k = 0; k < 4; k++) got_op[k] = '0;

    while (post < 2 && cyc < 300) begin
      @(negedge clk);
      ready_MEM_L2 = 1'b0;
      cyc++;
      if (done) post++;
      if (read_L2_MEM && write_L2_MEM) mutex_n++;
      cur_kind = write_L2_MEM ? 1 : (read_L2_MEM ? 2 : 0);
      if (cur_kind != 0) begin
        if (cur_kind != prev_kind) begin
          if (got_nops < 4) got_op[got_nops] = {write_L2_MEM, addr_L2_MEM};
          got_nops++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
        if (wait_n == ((cur_kind == 1) ? lw : lr)) ready_MEM_L2 = 1'b1;
      end
      prev_kind = cur_kind;
      #1;
      if (refill_L2) refill_n++;
      if (update_L2) update_n++;
      if (ready_L2_L1) begin
        ready_n++;
        if (!done) begin
          done        = 1'b1;
          done_cyc    = cyc;
          idx_at_done = index_L2;
        end
      end
      if (done && ((post == 0 && !hold) || post == 2)) begin
        write_L1_L2 = 1'b0;
        if (!with_read) read_L1_L2 = 1'b0;
      end
    end
    ready_MEM_L2 = 1'b0;

    check("done_seen", 64'(done), 64'(1));
    check("latency", 64'(done_cyc), 64'(exp_lat));
    check("ready_pulses", 64'(ready_n), 64'(1));
    check("mem_op_count", 64'(got_nops), 64'(exp_nops));
    for (int k = 0; k < exp_nops && k < got_nops; k++)
      check("mem_op", 64'(got_op[k]), 64'(exp_op[k]));
    check("refill_count", 64'(refill_n), 64'(rmiss));
    check("update_count", 64'(update_n), 64'(is_wr));
    check("index_L2", 64'(idx_at_done), 64'(li));
    check("mem_mutex", 64'(mutex_n), 64'(0));
  endtask

  // No request pending: nothing may happen, even with a stray memory ready pulse.
  task automatic idle_check(input int n);
    int act;
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ready_MEM_L2 = (k == 1);
      #1;
      if (ready_L2_L1 || read_L2_MEM || write_L2_MEM || refill_L2 || update_L2) act++;
    end
    ready_MEM_L2 = 1'b0;
    check("idle_quiet", 64'(act), 64'(0));
  endtask

  initial begin
    bit          is_wr, both, hold;
    logic [19:0] t, rt;
    logic [5:0]  i;
    int          lw, lr, w;

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outputs()), 64'(0));
    nrst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", 64'(all_outputs()), 64'(0));

    run_txn(1'b0, 20'h00001, 6'h05, 0, 3, 1'b0, '0, 1'b0);
    run_txn(1'b0, 20'h00001, 6'h05, 0, 0, 1'b0, '0, 1'b0);
    run_txn(1'b1, 20'h00001, 6'h05, 0, 0, 1'b0, '0, 1'b0);
    run_txn(1'b0, 20'h00005, 6'h05, 2, 1, 1'b0, '0, 1'b0);
    run_txn(1'b0, 20'h00001, 6'h05, 0, 0, 1'b0, '0, 1'b0);

    run_txn(1'b1, 20'h00009, 6'h05, 1, 0, 1'b1, 20'h00005, 1'b0);
    run_txn(1'b0, 20'h00005, 6'h05, 0, 2, 1'b0, '0, 1'b0);

    run_txn(1'b0, 20'h00005, 6'h05, 0, 0, 1'b0, '0, 1'b1);
    idle_check(6);

    for (int n = 0; n < 200; n++) begin
      is_wr = ($urandom_range(0, 2) == 0);
      both  = is_wr && ($urandom_range(0, 4) == 0);
      hold  = !is_wr && ($urandom_range(0, 7) == 0);
      t     = 20'($urandom_range(0, 15));
      rt    = 20'($urandom_range(0, 15));
      i     = 6'($urandom_range(0, 3));
      lw    = $urandom_range(0, 3);
      lr    = $urandom_range(0, 3);
      run_txn(is_wr, t, i, lw, lr, both, rt, hold);
      if (both) run_txn(1'b0, rt, i, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, '0, 1'b0);
    end

    read_L1_L2  = 1'b1;
    tag_L1_L2   = 20'hFFFFF;
    index_L1_L2 = 6'h3F;
    w = 0;
    while (!read_L2_MEM && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("reached_allocate", 64'(read_L2_MEM), 64'(1));
    nrst = 1'b0;
    read_L1_L2 = 1'b0;
    #1;
    check("reset_abort_read", 64'(read_L2_MEM), 64'(0));
    repeat (3) @(negedge clk);
    check("reset_held_outputs", 64'(all_outputs()), 64'(0));
    nrst = 1'b1;
    model_reset();
    @(negedge clk);
    run_txn(1'b0, 20'hFFFFF, 6'h3F, 0, 1, 1'b0, '0, 1'b0);
    run_txn(1'b0, 20'h00001, 6'h05, 0, 0, 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_controller.md
Name: l2_controller

Overview:
- Controller for a direct-mapped, write-back, write-allocate unified L2 cache.
- Sits directly downstream of the L1 controllers and serves block reads (L1 refill) and block writes (L1 dirty eviction).
- Owns the L2 tag/valid/dirty state and the L2<->memory handshake.
- Data arrays are external and steered by the strobes this block produces.

Parameters:
- ADDR_W, 26: block address width; equals L1 tag width (20) plus L1 index width (6).
- IDX_W, 8: L2 index width. L2 holds 2^IDX_W lines. Tag width is ADDR_W-IDX_W.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- read_L1_L2  in  1  L1 block read request; level, held until serviced.
- write_L1_L2  in  1  L1 block write (eviction) request; level.
- tag_L1_L2  in  20  L1 tag for read requests.
- write_tag_L1_L2  in  20  L1 victim tag for write requests.
- index_L1_L2  in  6  L1 index.
- ready_L2_L1  out  1  request done; one-cycle pulse.
- read_L2_MEM  out  1  memory block read request; level.
- write_L2_MEM  out  1  memory block write request; level.
- addr_L2_MEM  out  ADDR_W  memory block address.
- ready_MEM_L2  in  1  memory done; one-cycle pulse.
- index_L2  out  IDX_W  L2 data array line select.
- refill_L2  out  1  data array captures memory read data this cycle.
- update_L2  out  1  data array captures L1 write data this cycle.

Behaviour:
- Reset: state=S_IDLE; valid, dirty and the tag array all cleared; all outputs 0. Reset asserted mid-transaction aborts it with no further memory strobes.
- Address formation:
  - Request address is {write_tag_L1_L2,index_L1_L2} when write_L1_L2=1, else {tag_L1_L2,index_L1_L2}.
  - L2 index = addr[IDX_W-1:0]; L2 tag = addr[ADDR_W-1:IDX_W].
  - Address and op are latched in S_IDLE on acceptance. Inputs are ignored after that until the next acceptance.
- Request priority: write wins if both requests are high. The read is taken on a later acceptance.
- State S_IDLE: if a request is present, latch it and go to S_COMPARE.
- State S_COMPARE: hit = valid[idx] && TAG[idx]==latched tag. This is a combinational compare on latched values and takes one cycle.
  - Read, hit: go to S_DONE.
  - Read, miss, valid&&dirty: go to S_WRITE_BACK.
  - Read, miss, otherwise: go to S_ALLOCATE.
  - Write, hit or non-dirty miss: in this cycle update_L2=1, TAG=tag, valid=1, dirty=1; go to S_DONE. No memory read, since a full block is written.
  - Write, miss, valid&&dirty: go to S_WRITE_BACK.
- State S_WRITE_BACK: write_L2_MEM=1 and addr_L2_MEM={TAG[idx],idx}.
  - On ready_MEM_L2, clear dirty[idx].
  - Then go to S_COMPARE for a write (it now installs) or S_ALLOCATE for a read.
- State S_ALLOCATE: read_L2_MEM=1 and addr_L2_MEM=latched address.
  - On ready_MEM_L2: refill_L2=1 in that same cycle, TAG=tag, valid=1, dirty=0; go to S_COMPARE, which then hits.
- State S_DONE: ready_L2_L1=1 for exactly this cycle; go to S_GUARD.
- State S_GUARD: one cycle in which requests are ignored, so a requester that drops its request one cycle late is not re-accepted. Go to S_IDLE.
- Output timing rules:
  - read_L2_MEM, write_L2_MEM, ready_L2_L1 and addr_L2_MEM are Moore outputs decoded from the state. addr_L2_MEM=0 outside S_WRITE_BACK and S_ALLOCATE.
  - refill_L2 and update_L2 are combinational with the transition and last one cycle.
  - index_L2 = latched index at all times.
- Memory handshake: memory requests stay high until ready_MEM_L2. A ready_MEM_L2 seen outside S_WRITE_BACK or S_ALLOCATE is ignored.
- Latency with 0-wait memory, counted from request sampled in S_IDLE to ready_L2_L1:
  - Read hit: 2 cycles.
  - Clean miss: 2 + memory latency + 2 cycles.
  - Dirty miss: additionally adds the write-back latency.
- Invariant: at most one of read_L2_MEM and write_L2_MEM is high in any cycle.

Test Plan:
- After reset, read tag=20'h00001 idx=6'h05 (addr 26'h000045): S_ALLOCATE drives read_L2_MEM=1 with addr_L2_MEM=26'h000045. Memory ready after 3 cycles gives refill_L2=1 for 1 cycle and index_L2=8'h45. Then ready_L2_L1 pulses exactly once, and a second identical read hits with ready 2 cycles after acceptance and no memory traffic.
- Write write_tag=20'h00001 idx=6'h05 to the resident line: update_L2=1 and dirty[8'h45]=1; no read_L2_MEM or write_L2_MEM assertion.
- Read addr 26'h000145 (same L2 index, tag 18'h1) while line 8'h45 is dirty: write_L2_MEM first with addr 26'h000045, then read_L2_MEM with addr 26'h000145. The new line ends clean, and ready_L2_L1 pulses once.
- Simultaneous read and write requests: the write is serviced first. A requester that holds read one cycle past ready_L2_L1 is not re-accepted; the held read is accepted after S_GUARD.
- Deassert nrst while read_L2_MEM=1: read_L2_MEM drops immediately, and the following read of the same address misses because valid was cleared.
